// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin arbiter that hands a shared counter to one requester at a
//   time. The winner's terminal count is latched at grant. The counter then
//   runs from 0 up to that value, and the owner receives a one-cycle done
//   pulse. If the owner drops its request during the count, the window is
//   abandoned and no done pulse is issued.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [NUM_REQ]        level requests
//   target  in   [NUM_REQ*CNT_W]  per-requester terminal count, packed
//   gnt     out  [NUM_REQ]        one-hot grant while counting
//   en_cnt  out  counter enable (COUNT state)
//   count   out  [CNT_W]          current count of the active window
//   done    out  [NUM_REQ]        one-cycle completion pulse to the owner
//   busy    out  high whenever not IDLE
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] target,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     en_cnt,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] tgt;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] owner_inc;
    logic             owner_req;
    logic             at_tgt;

    // Round-robin search: first set request at or after ptr, wrapping.
    always_comb begin
        logic [IDX_W:0] pos;
        found = 1'b0;
        win   = ptr;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ))
                pos = pos - (IDX_W+1)'(NUM_REQ);
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = pos[IDX_W-1:0];
            end
        end
    end

    assign owner_inc = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
    assign owner_req = req[owner];
    assign at_tgt    = (count == tgt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: abort (owner released request) wins over terminal count.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = COUNT;
            COUNT: begin
                if (!owner_req)  state_nxt = IDLE;
                else if (at_tgt) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the latched owner
    always_comb begin
        gnt    = '0;
        done   = '0;
        en_cnt = 1'b0;
        busy   = (state != IDLE);
        case (state)
            COUNT: begin
                gnt[owner] = 1'b1;
                en_cnt     = 1'b1;
            end
            DONE:    done[owner] = 1'b1;
            default: ;
        endcase
    end

    // Datapath: owner/target latch at grant, count, round-robin pointer.
    // count is left untouched outside COUNT so the last value stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            owner <= '0;
            tgt   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= win;
                        tgt   <= target[win*CNT_W +: CNT_W];
                        count <= '0;
                    end
                end
                COUNT: begin
                    if (!owner_req)
                        ptr <= owner_inc;
                    else if (!at_tgt)
                        count <= count + 1'b1;
                end
                DONE:    ptr <= owner_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the counter.
REQ-002 SHALL have parameter CNT_W, default 8, width of count and target values.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester request, level, held until done or abandoned.
REQ-006 SHALL have port target  input  NUM_REQ*CNT_W  packed; requester i terminal count at bits [i*CNT_W +: CNT_W].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot grant; all-zero when no owner.
REQ-008 SHALL have port en_cnt  output  1  enable to the shared counter.
REQ-009 SHALL have port count  output  CNT_W  current count of the active window.
REQ-010 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, COUNT, DONE.
REQ-013 IDLE: if any req bit high, SHALL pick winner by round robin, searching upward from pointer ptr with wrap; next cycle -> COUNT, gnt[winner]=1, count=0, latched target = target[winner].
REQ-014 IDLE with req all-zero SHALL stay in IDLE, gnt=0, en_cnt=0.
REQ-015 COUNT: en_cnt=1; count SHALL increment by 1 per cycle while count != latched target.
REQ-016 COUNT with count == latched target SHALL -> DONE next cycle; count SHALL NOT increment or wrap past target.
REQ-017 DONE: done[winner]=1 for exactly one cycle, gnt=0, en_cnt=0, ptr = winner+1 mod NUM_REQ; next cycle -> IDLE.
REQ-018 Latency: req seen in IDLE at cycle c -> gnt at c+1; done pulse at c+2+T (T = latched target); next grant no earlier than c+4+T.
REQ-019 Target 0 SHALL yield one COUNT cycle (count=0) then DONE.
REQ-020 target input SHALL be sampled only at grant; later changes SHALL be ignored for that window.
REQ-021 Abort: req[winner] low during COUNT SHALL -> IDLE next cycle, gnt=0, en_cnt=0, no done pulse, ptr = winner+1 mod NUM_REQ.
REQ-022 Abort takes priority over terminal count in the same cycle.
REQ-023 Requests from non-owners SHALL be ignored until IDLE; no preemption.
REQ-024 count SHALL hold its last value in DONE and IDLE until the next grant reloads 0.
REQ-025 gnt SHALL be one-hot or zero at all times; done SHALL be one-hot or zero and only on the bit just granted.

Reset
REQ-026 rst high SHALL force, at the next edge: state IDLE, ptr=0, gnt=0, en_cnt=0, count=0, done=0, busy=0, latched target=0.
REQ-027 rst mid-COUNT or in DONE SHALL abandon the window with no done pulse; rst SHALL override all other inputs.
REQ-028 First arbitration after reset SHALL favour requester 0.

Verification
REQ-029 rst 2 cycles, req=4'b0001, target0=3 -> gnt=0001 next cycle; count 0,1,2,3; done[0] pulse at cycle 5 after req; busy low after.
REQ-030 req=4'b1111 held, all targets=0 -> grants in order 0,1,2,3,0 each 1 COUNT cycle, one done per grant, never two gnt bits.
REQ-031 req[2] only, target2=5; drop req[2] when count=2 -> gnt=0 next cycle, no done[2], count holds 2, next grant searches from 3.
REQ-032 target0=255 -> count reaches 255, holds, DONE follows; no wrap to 0 while gnt high.
REQ-033 rst asserted while count=4 of target 10 -> next cycle all outputs 0, IDLE; then req=4'b0110 -> gnt=0010.
REQ-034 change target1 from 2 to 9 during requester 1's COUNT -> window still ends at count 2.
